// File: rtl/mmio_led_ctrl.sv
// mmio_led_ctrl: memory-mapped LED peripheral sitting beside data RAM on the
// MEM-stage data bus. It holds the LED enable register and, optionally, a
// per-LED 8-bit duty register that drives a free-running PWM dimmer.
// Optional feature macro: MMIO_LED_PWM_EN (PWM counter, LED_DUTY storage and
// PWM_CNT readback). Without it LED_DUTY/PWM_CNT decode as hits but read 0.
module mmio_led_ctrl #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ALEN      = 32,
  parameter int unsigned     LED_WIDTH = 4,
  parameter logic [ALEN-1:0] BASE_ADDR = 32'hFFFF_FFF0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ALEN-1:0]      bus_addr,
  input  logic [XLEN-1:0]      bus_wdata,
  input  logic                 bus_we,
  input  logic                 bus_re,
  input  logic [2:0]           bus_funct3,
  output logic                 bus_hit,
  output logic [XLEN-1:0]      bus_rdata,
  output logic                 bus_rvalid,
  output logic [LED_WIDTH-1:0] leds_o
);

  // funct3 store-size encodings (RISC-V SB/SH/SW)
  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

  // Register select within the 16-byte window (addr[3:2])
  localparam logic [1:0] SEL_CTRL = 2'b00;
  localparam logic [1:0] SEL_DUTY = 2'b01;
  localparam logic [1:0] SEL_CNT  = 2'b10;

  logic [1:0]             w_sel;
  logic                   w_store;
  logic [3:0]             w_be;
  logic [XLEN-1:0]        w_rd_word;
  logic [8*LED_WIDTH-1:0] w_duty_rd;
  logic [7:0]             w_cnt_rd;
  logic [LED_WIDTH-1:0]   w_led_on;
  logic                   w_unused;

  logic [LED_WIDTH-1:0]   r_ctrl;
  logic [XLEN-1:0]        r_rdata;
  logic                   r_rvalid;
  logic [LED_WIDTH-1:0]   r_leds;

  // Window match, with the +0xC slot left unmapped
  assign bus_hit = (bus_addr[ALEN-1:4] == BASE_ADDR[ALEN-1:4]) && (bus_addr[3:2] != 2'b11);
  assign w_sel   = bus_addr[3:2];
  assign w_store = bus_we && bus_hit;

  // Byte-lane enables from store size; misaligned or unknown sizes enable nothing
  always_comb begin
    w_be = 4'b0000;
    case (bus_funct3)
      F3_BYTE: w_be = 4'b0001 << bus_addr[1:0];
      F3_HALF: begin
        if (bus_addr[0]) begin
          w_be = 4'b0000;
        end else if (bus_addr[1]) begin
          w_be = 4'b1100;
        end else begin
          w_be = 4'b0011;
        end
      end
      F3_WORD: begin
        if (bus_addr[1:0] == 2'b00) begin
          w_be = 4'b1111;
        end else begin
          w_be = 4'b0000;
        end
      end
      default: w_be = 4'b0000;
    endcase
  end

  // LED enable register: only lane 0 carries enable bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
    end else if (w_store && (w_sel == SEL_CTRL) && w_be[0]) begin
      r_ctrl <= bus_wdata[LED_WIDTH-1:0];
    end
  end

`ifdef MMIO_LED_PWM_EN
  logic [7:0]             r_cnt;
  logic [8*LED_WIDTH-1:0] r_duty;

  // Free-running PWM counter, wraps 0xFF -> 0x00
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'h00;
    end else begin
      r_cnt <= r_cnt + 8'h01;
    end
  end

  // Duty register: one byte per LED, written per enabled lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '1;
    end else if (w_store && (w_sel == SEL_DUTY)) begin
      for (int i = 0; i < LED_WIDTH; i++) begin
        if (w_be[i]) begin
          r_duty[8*i +: 8] <= bus_wdata[8*i +: 8];
        end
      end
    end
  end

  // PWM compare; duty 0xFF is forced fully on instead of 255/256
  always_comb begin
    w_led_on = '0;
    for (int i = 0; i < LED_WIDTH; i++) begin
      if (r_ctrl[i] && ((r_duty[8*i +: 8] == 8'hFF) || (r_cnt < r_duty[8*i +: 8]))) begin
        w_led_on[i] = 1'b1;
      end else begin
        w_led_on[i] = 1'b0;
      end
    end
  end

  assign w_duty_rd = r_duty;
  assign w_cnt_rd  = r_cnt;
`else
  assign w_led_on  = r_ctrl;
  assign w_duty_rd = '0;
  assign w_cnt_rd  = 8'h00;
`endif

  // Aligned read word for the selected register, upper bits zero
  always_comb begin
    w_rd_word = '0;
    case (w_sel)
      SEL_CTRL: w_rd_word[LED_WIDTH-1:0]   = r_ctrl;
      SEL_DUTY: w_rd_word[8*LED_WIDTH-1:0] = w_duty_rd;
      SEL_CNT:  w_rd_word[7:0]             = w_cnt_rd;
      default:  w_rd_word                  = '0;
    endcase
  end

  // Load response: one-cycle latency; rdata holds across non-hit loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus_re && bus_hit;
      if (bus_re && bus_hit) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  // Registered LED drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_leds <= '0;
    end else begin
      r_leds <= w_led_on;
    end
  end

  assign bus_rdata  = r_rdata;
  assign bus_rvalid = r_rvalid;
  assign leds_o     = r_leds;

  // Store data lanes and byte enables not consumed in every configuration
  assign w_unused = ^{bus_wdata, w_be};

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// tb_mmio_led_ctrl: scoreboard bench for mmio_led_ctrl. A driver issues
// directed and random bus accesses and updates a register-level reference
// model at each clock edge; a monitor on the falling edge compares LEDs,
// read data and rvalid against the model and the expected-read queue.
module tb_mmio_led_ctrl;

`ifdef MMIO_LED_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  localparam logic [31:0] A_CTRL = 32'hFFFF_FFF0;
  localparam logic [31:0] A_DUTY = 32'hFFFF_FFF4;
  localparam logic [31:0] A_CNT  = 32'hFFFF_FFF8;
  localparam logic [31:0] A_HOLE = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [2:0]  bus_funct3;
  logic        bus_hit;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic [3:0]  leds_o;

  mmio_led_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_funct3 (bus_funct3),
    .bus_hit    (bus_hit),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .leds_o     (leds_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0]  m_ctrl;
  logic [7:0]  m_duty [4];
  logic [7:0]  m_cnt;
  logic [3:0]  m_leds;
  logic [31:0] m_rdata;
  logic [31:0] exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl  = 4'h0;
    for (int i = 0; i < 4; i++) m_duty[i] = 8'hFF;
    m_cnt   = 8'h00;
    m_leds  = 4'h0;
    m_rdata = 32'h0;
    exp_q.delete();
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return (a[31:4] == 28'hFFFFFFF) && (a[3:2] != 2'b11);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h0;
    if (a[3:2] == 2'b00) w = {28'h0, m_ctrl};
    else if (a[3:2] == 2'b01 && PWM) w = {m_duty[3], m_duty[2], m_duty[1], m_duty[0]};
    else if (a[3:2] == 2'b10 && PWM) w = {24'h0, m_cnt};
    return w;
  endfunction

  // Apply one clock edge of architectural behaviour to the model
  task automatic model_edge(input logic we, input logic re, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] f3);
    logic [3:0] nl;
    logic [3:0] lanes;
    bit h;
    h = model_hit(a);
    for (int i = 0; i < 4; i++) begin
      if (PWM) nl[i] = m_ctrl[i] && ((m_duty[i] == 8'hFF) || (m_cnt < m_duty[i]));
      else     nl[i] = m_ctrl[i];
    end
    if (re && h) begin
      m_rdata = model_read(a);
      exp_q.push_back(m_rdata);
    end
    lanes = 4'b0000;
    if (f3 == 3'd0) lanes = 4'b0001 << a[1:0];
    else if (f3 == 3'd1 && !a[0]) lanes = a[1] ? 4'b1100 : 4'b0011;
    else if (f3 == 3'd2 && a[1:0] == 2'b00) lanes = 4'b1111;
    if (we && h) begin
      if (a[3:2] == 2'b00 && lanes[0]) m_ctrl = wd[3:0];
      if (a[3:2] == 2'b01 && PWM) begin
        for (int i = 0; i < 4; i++) if (lanes[i]) m_duty[i] = wd[8*i +: 8];
      end
    end
    m_leds = nl;
    m_cnt  = m_cnt + 8'd1;
  endtask

  // Drive one bus cycle, check decode, then advance the model at the edge
  task automatic step(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] f3);
    @(negedge clk);
    bus_we = we; bus_re = re; bus_addr = a; bus_wdata = wd; bus_funct3 = f3;
    #1;
    chk("bus_hit", {31'h0, bus_hit}, {31'h0, model_hit(a)});
    @(posedge clk);
    model_edge(we, re, a, wd, f3);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
  endtask

  // Monitor: compare outputs and pop expected reads on rvalid
  always @(negedge clk) begin
    bit exp_v;
    logic [31:0] e;
    if (rst_n) begin
      chk("leds", {28'h0, leds_o}, {28'h0, m_leds});
      chk("rdata_hold", bus_rdata, m_rdata);
      exp_v = (exp_q.size() != 0);
      chk("rvalid", {31'h0, bus_rvalid}, {31'h0, exp_v});
      if (exp_v) begin
        e = exp_q.pop_front();
        if (bus_rvalid) chk("rdata", bus_rdata, e);
      end
    end
  end

  initial begin
    int on1;
    logic any0;
    logic [31:0] a;
    logic [2:0]  f3;
    rst_n = 1'b0;
    bus_we = 1'b0; bus_re = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0; bus_funct3 = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", bus_rdata, 32'h0);
    chk("reset_rvalid", {31'h0, bus_rvalid}, 32'h0);
    chk("reset_leds", {28'h0, leds_o}, 32'h0);
    #1 rst_n = 1'b1;

    // Enable LEDs 0 and 2 with default duty, then read back
    step(1'b1, 1'b0, A_CTRL, 32'h0000_0005, 3'd2);
    idle();
    #1 chk("leds_after_sw", {28'h0, leds_o}, 32'h5);
    step(1'b0, 1'b1, A_CTRL, 32'h0, 3'd2);
    #1 chk("lw_ctrl", bus_rdata, 32'h0000_0005);
    chk("lw_ctrl_rvalid", {31'h0, bus_rvalid}, 32'h1);

`ifdef MMIO_LED_PWM_EN
    // Half duty on LED1 only
    step(1'b1, 1'b0, A_CTRL, 32'h0000_0002, 3'd2);
    step(1'b1, 1'b0, 32'hFFFF_FFF5, 32'h0000_8000, 3'd0);
    step(1'b0, 1'b1, A_DUTY, 32'h0, 3'd2);
    #1 chk("duty_rd", bus_rdata, 32'hFFFF_80FF);
    on1 = 0;
    any0 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      idle();
      #1;
      if (leds_o[1]) on1++;
      any0 = any0 | leds_o[0];
    end
    chk("led1_on_cycles", on1, 32'd128);
    chk("led0_off", {31'h0, any0}, 32'h0);
`else
    // Duty/count registers are stubs without the dimmer
    step(1'b1, 1'b0, A_CTRL, 32'h0000_000F, 3'd2);
    step(1'b1, 1'b0, A_DUTY, 32'h0000_0000, 3'd2);
    idle();
    #1 chk("leds_nopwm", {28'h0, leds_o}, 32'hF);
    step(1'b0, 1'b1, A_DUTY, 32'h0, 3'd2);
    #1 chk("duty_rd_nopwm", bus_rdata, 32'h0);
    step(1'b0, 1'b1, A_CNT, 32'h0, 3'd2);
    #1 chk("cnt_rd_nopwm", bus_rdata, 32'h0);
`endif

    // Misaligned stores are dropped but still decode; the hole never answers
    step(1'b1, 1'b0, A_CTRL, 32'h0000_0003, 3'd2);
    step(1'b1, 1'b0, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 3'd1);
    step(1'b1, 1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFF, 3'd2);
    step(1'b0, 1'b1, A_CTRL, 32'h0, 3'd2);
    #1 chk("misaligned_ctrl", bus_rdata, 32'h3);
    step(1'b0, 1'b1, A_HOLE, 32'h0, 3'd2);
    #1 chk("hole_no_rvalid", {31'h0, bus_rvalid}, 32'h0);

    // Same-cycle store and load return the pre-store value
    step(1'b1, 1'b0, A_CTRL, 32'h0, 3'd2);
    step(1'b1, 1'b1, A_CTRL, 32'h0000_000F, 3'd2);
    #1 chk("same_cycle_old", bus_rdata, 32'h0);
    step(1'b0, 1'b1, A_CTRL, 32'h0, 3'd2);
    #1 chk("same_cycle_new", bus_rdata, 32'hF);

    // Asynchronous reset between edges with a load response in flight
    idle();
    step(1'b0, 1'b1, A_CTRL, 32'h0, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_leds", {28'h0, leds_o}, 32'h0);
    chk("async_rst_rvalid", {31'h0, bus_rvalid}, 32'h0);
    chk("async_rst_rdata", bus_rdata, 32'h0);
    model_reset();
    bus_we = 1'b0; bus_re = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0; bus_funct3 = 3'd0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b0, 1'b1, A_CTRL, 32'h0, 3'd2);
    #1 chk("post_rst_ctrl", bus_rdata, 32'h0);
    step(1'b0, 1'b1, A_DUTY, 32'h0, 3'd2);
    #1 chk("post_rst_duty", bus_rdata, PWM ? 32'hFFFF_FFFF : 32'h0);

    // Random accesses against the model
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        8:       a = 32'hFFFF_FFE0 | 32'($urandom_range(0, 15));
        9:       a = $urandom;
        default: a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 9) < 7) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, $urandom, f3);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
